// File: rtl/sc_conv_pkg.sv
// Shared types and helpers for the stochastic-to-binary converters.
package sc_conv_pkg;

    typedef enum logic [1:0] {IDLE, WARMUP, ACCUM, HOLD} sbs2b_state_t;

    function automatic int unsigned sat_clamp(input int unsigned value, input int unsigned max_value);
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/sbs_win_counter.sv
// Enable-qualified up-counter with synchronous clear; last flags the LIMIT-th qualified cycle.
module sbs_win_counter #(
    parameter int unsigned W     = 8,
    parameter int unsigned LIMIT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    // last is high while count == LIMIT-1, so the owner acts on the same edge that consumes the final bit
    localparam logic [W-1:0] LAST_COUNT = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign last = (count == LAST_COUNT);

endmodule

// File: rtl/sbs_to_bin.sv
// Counts ones of a unipolar stochastic bitstream over a 2^CWIDTH window after a warm-up prefix.
module sbs_to_bin
    import sc_conv_pkg::*;
#(
    parameter int unsigned CWIDTH = 8,
    parameter int unsigned WARMUP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clr,
    input  logic              in_bit,
    input  logic              in_en,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CWIDTH-1:0] out_value,
    output logic              out_sat
);

    localparam int unsigned WIN  = 1 << CWIDTH;
    localparam int unsigned WU_W = (WARMUP == 0) ? 1 : $clog2(WARMUP + 1);
    localparam sbs2b_state_t FIRST_ST = (WARMUP == 0) ? ACCUM : sc_conv_pkg::WARMUP;

    sbs2b_state_t    state;
    logic [CWIDTH:0] acc;
    logic [CWIDTH:0] acc_next;
    logic            go;
    logic            cnt_clr;
    logic            wu_last;
    logic            win_last;

    assign acc_next = acc + {{CWIDTH{1'b0}}, in_bit};
    assign go       = start && ((state == IDLE) || ((state == HOLD) && out_ready));
    assign cnt_clr  = clr || go;

    sbs_win_counter #(.W(WU_W), .LIMIT(WARMUP)) u_warmup_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    ((state == sc_conv_pkg::WARMUP) && in_en),
        .last  (wu_last)
    );

    sbs_win_counter #(.W(CWIDTH + 1), .LIMIT(WIN)) u_window_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    ((state == ACCUM) && in_en),
        .last  (win_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_value <= '0;
            out_sat   <= 1'b0;
            acc       <= '0;
        end else if (clr) begin
            // out_value/out_sat deliberately keep the last completed result
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state <= FIRST_ST;
                        busy  <= 1'b1;
                        acc   <= '0;
                    end
                end
                sc_conv_pkg::WARMUP: begin
                    if (in_en && wu_last) begin
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_en) begin
                        acc <= acc_next;
                        if (win_last) begin
                            state     <= HOLD;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            out_value <= CWIDTH'(sat_clamp(32'(acc_next), WIN - 1));
                            out_sat   <= (acc_next == (CWIDTH + 1)'(WIN));
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= go ? FIRST_ST : IDLE;
                        busy      <= go;
                        acc       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sbs_to_bin.md
Name: sbs_to_bin

Overview:
- Downstream consumer of the stochastic divider output.
- Converts a unipolar stochastic bitstream into a binary value by counting ones over a fixed window of 2^CWIDTH valid bits.
- Discards a configurable warm-up prefix so the divider's shift-register settling does not bias the result.
- Presents the result on a valid/ready output port for the binary-domain checker or next stage.

Parameters:
- CWIDTH, 8, result width; window length = 2^CWIDTH qualified bits.
- WARMUP, 4, number of qualified bits discarded after start before counting (0 allowed).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a new conversion; honoured only in IDLE, or in HOLD on the handshake cycle.
- clr  input  1  synchronous abort; returns to IDLE and discards the partial count.
- in_bit  input  1  stochastic bit, e.g. the divider quotient.
- in_en  input  1  in_bit qualifier; only cycles with in_en=1 advance warm-up or window counters.
- busy  output  1  high in WARMUP or ACCUM.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_value  output  CWIDTH  ones count, saturated.
- out_sat  output  1  high when the raw count was 2^CWIDTH and out_value was clamped.

Behaviour:
- Reset (rst_n low, async): state IDLE; busy=0, out_valid=0, out_value=0, out_sat=0; all counters 0.
- States: IDLE, WARMUP, ACCUM, HOLD.
- IDLE:
  - start=1 -> WARMUP, or ACCUM if WARMUP=0.
  - Warm-up counter, window counter and ones accumulator clear on entry.
- WARMUP:
  - Each in_en=1 cycle increments the warm-up counter; in_bit is ignored.
  - After the WARMUP-th qualified bit -> ACCUM next cycle.
- ACCUM:
  - Each in_en=1 cycle adds in_bit to a CWIDTH+1-bit accumulator and increments the window counter.
  - After the 2^CWIDTH-th qualified bit -> HOLD.
  - On that transition, out_value = min(acc, 2^CWIDTH-1) and out_sat = (acc == 2^CWIDTH).
  - The final bit is included in the result.
- HOLD:
  - out_valid=1; out_value and out_sat are held stable until the handshake.
  - out_valid & out_ready -> IDLE, or -> WARMUP/ACCUM if start=1 in the same cycle (back-to-back conversion).
  - start without out_ready is ignored.
- Latency: with in_en constantly 1 and start sampled at edge k, out_valid rises after edge k+WARMUP+2^CWIDTH.
- start in WARMUP/ACCUM: ignored, no restart.
- clr: highest-priority synchronous event in any state -> IDLE.
  - out_valid drops the next cycle.
  - out_value and out_sat keep their last values.
  - clr and start together -> IDLE; start is dropped.
- in_en=0: holds every counter; the state does not change except on clr or a handshake.
- Window counter: CWIDTH+1 bits; compared against 2^CWIDTH, no wrap.
- out_value/out_sat change only on the ACCUM->HOLD transition or reset.

Decomposition:
- Shared package sc_conv_pkg holds:
  - typedef enum logic [1:0] sbs2b_state_t {IDLE, WARMUP, ACCUM, HOLD};
  - a saturating-clamp function reused by other converters.
- One sub-module, sbs_win_counter: an enable-qualified counter with clear and a terminal-count flag.
  - Instantiated twice: warm-up (WARMUP bound) and window (2^CWIDTH bound).

Test Plan:
- CWIDTH=4, WARMUP=2, in_en=1, in_bit=1 constant, start at edge 0 -> out_valid rises after edge 18, out_value=15, out_sat=1, busy low in the same cycle.
- Same setup, in_bit alternating 1,0 from the first counted bit -> out_value=8, out_sat=0. Warm-up bits forced to 1 do not change the result.
- in_en toggling 1,0 every cycle, in_bit=1 only on qualified cycles with count target 5 -> out_value=5; latency doubles to 36 cycles.
- Result pending, out_ready held low 5 cycles with start pulsed in HOLD:
  - out_value and out_valid stay stable; the start is ignored.
  - out_ready=1 together with start=1 -> next cycle busy=1, state WARMUP, out_valid=0.
- clr asserted mid-ACCUM (after 7 counted bits) -> IDLE next cycle, busy=0, no out_valid.
  - A fresh start then yields a correct full 16-bit window count.
- rst_n dropped asynchronously mid-WARMUP and mid-HOLD -> all outputs 0 immediately.
  - After release, no activity until start.
